// File: rtl/fir_cfg_pkg.sv
// rtl/fir_cfg_pkg.sv - register map, control bits, FSM states and error codes for the FIR config sequencer
package fir_cfg_pkg;

  // FIR AXI-Lite register offsets
  localparam logic [11:0] REG_CTRL     = 12'h000;
  localparam logic [11:0] REG_LEN      = 12'h010;
  localparam logic [11:0] REG_TAP_BASE = 12'h020;

  // Bit positions inside the control/status register
  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  // Word written to the control register to launch the FIR
  localparam logic [31:0] CTRL_START_WORD = 32'd1 << AP_START;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_LEN     = 3'd1,
    S_WR_TAP     = 3'd2,
    S_RD_TAP     = 3'd3,
    S_WR_START   = 3'd4,
    S_POLL_RD    = 3'd5,
    S_POLL_WAIT  = 3'd6,
    S_DONE       = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TAP     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

  // Byte address of coefficient k
  function automatic logic [11:0] tap_addr(input logic [3:0] k);
    return REG_TAP_BASE + {6'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/fir_cfg_sequencer_xact.sv
// rtl/fir_cfg_sequencer_xact.sv - single outstanding AXI-Lite read or write transaction engine
module axil_master_xact #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              xact_busy,
  output logic              ack,
  output logic [DATA_W-1:0] rsp_data,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata
);

  logic active;
  logic we_q;
  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic r_hs;
  logic wr_complete;
  logic rd_complete;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // A write finishes once both channels have handshaken, in any order or together
  assign wr_complete = active & we_q & (aw_done | aw_hs) & (w_done | w_hs);
  assign rd_complete = active & ~we_q & r_hs;
  assign ack         = wr_complete | rd_complete;
  assign rsp_data    = rdata;
  assign xact_busy   = active;

  // Launch on req when idle, drop each valid after its own handshake, retire on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      we_q    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awvalid <= 1'b0;
      awaddr  <= '0;
      wvalid  <= 1'b0;
      wdata   <= '0;
      arvalid <= 1'b0;
      araddr  <= '0;
      rready  <= 1'b0;
    end else if (!active) begin
      if (req) begin
        active  <= 1'b1;
        we_q    <= req_we;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (req_we) begin
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          awaddr  <= req_addr;
          wdata   <= req_wdata;
        end else begin
          arvalid <= 1'b1;
          rready  <= 1'b1;
          araddr  <= req_addr;
        end
      end
    end else begin
      if (aw_hs) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if (ar_hs) arvalid <= 1'b0;
      if (r_hs)  rready  <= 1'b0;
      if (ack) begin
        active  <= 1'b0;
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        arvalid <= 1'b0;
        rready  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_cfg_sequencer.sv
// rtl/fir_cfg_sequencer.sv - programs, verifies, starts and polls the FIR engine over AXI-Lite
module fir_cfg_sequencer
  import fir_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_GAP    = 8,
  parameter int POLL_MAX    = 65535
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   go,
  input  logic [31:0]            cfg_len,
  input  logic [Tape_Num*32-1:0] cfg_taps,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [3:0]             err_idx,
  output logic [31:0]            status,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  seq_state_t             state;
  seq_state_t             next_state;
  err_code_t              err_q;

  logic [31:0]            len_q;
  logic [pDATA_WIDTH-1:0] taps_q [Tape_Num];
  logic [3:0]             tap_k;
  logic [31:0]            poll_cnt;
  logic [15:0]            gap_cnt;

  logic                   req;
  logic                   req_we;
  logic [pADDR_WIDTH-1:0] req_addr;
  logic [pDATA_WIDTH-1:0] req_wdata;
  logic                   xact_busy;
  logic                   ack;
  logic [pDATA_WIDTH-1:0] rsp_data;

  logic                   go_accept;
  logic                   last_tap;
  logic                   tap_mismatch;
  logic                   poll_last;
  logic                   gap_last;
  logic                   fir_done;

  assign go_accept    = go && (state == S_IDLE);
  assign last_tap     = (tap_k == 4'(Tape_Num - 1));
  assign tap_mismatch = (rsp_data != taps_q[tap_k]);
  assign poll_last    = (poll_cnt == 32'(POLL_MAX - 1));
  assign gap_last     = (gap_cnt == 16'(POLL_GAP - 1));
  assign fir_done     = rsp_data[AP_DONE];
  assign err_code     = err_q;

  axil_master_xact #(
    .ADDR_W (pADDR_WIDTH),
    .DATA_W (pDATA_WIDTH)
  ) u_xact (
    .clk       (axis_clk),
    .rst_n     (axis_rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .xact_busy (xact_busy),
    .ack       (ack),
    .rsp_data  (rsp_data),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata)
  );

  // Sequencer state register
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= next_state;
  end

  // Step through program, verify, start and poll; any transaction state advances only on ack
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (go) next_state = S_WR_LEN;
      S_WR_LEN:    if (ack) next_state = S_WR_TAP;
      S_WR_TAP:    if (ack && last_tap) next_state = S_RD_TAP;
      S_RD_TAP: begin
        if (ack) begin
          if (tap_mismatch)  next_state = S_IDLE;
          else if (last_tap) next_state = S_WR_START;
        end
      end
      S_WR_START:  if (ack) next_state = S_POLL_RD;
      S_POLL_RD: begin
        if (ack) begin
          if (fir_done)       next_state = S_DONE;
          else if (poll_last) next_state = S_IDLE;
          else                next_state = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: if (gap_last) next_state = S_POLL_RD;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Transaction request for the current state, plus busy/done flags
  always_comb begin
    req       = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state)
      S_WR_LEN: begin
        req       = ~xact_busy;
        req_we    = 1'b1;
        req_addr  = pADDR_WIDTH'(REG_LEN);
        req_wdata = pDATA_WIDTH'(len_q);
      end
      S_WR_TAP: begin
        req       = ~xact_busy;
        req_we    = 1'b1;
        req_addr  = pADDR_WIDTH'(tap_addr(tap_k));
        req_wdata = taps_q[tap_k];
      end
      S_RD_TAP: begin
        req       = ~xact_busy;
        req_addr  = pADDR_WIDTH'(tap_addr(tap_k));
      end
      S_WR_START: begin
        req       = ~xact_busy;
        req_we    = 1'b1;
        req_addr  = pADDR_WIDTH'(REG_CTRL);
        req_wdata = pDATA_WIDTH'(CTRL_START_WORD);
      end
      S_POLL_RD: begin
        req       = ~xact_busy;
        req_addr  = pADDR_WIDTH'(REG_CTRL);
      end
      default: ;
    endcase
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  // Config capture, tap/poll/gap counters, sticky error reporting and status capture
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      len_q    <= '0;
      taps_q   <= '{default: '0};
      tap_k    <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      error    <= 1'b0;
      err_q    <= ERR_NONE;
      err_idx  <= '0;
      status   <= '0;
    end else begin
      if (go_accept) begin
        len_q <= cfg_len;
        for (int k = 0; k < Tape_Num; k++) begin
          taps_q[k] <= pDATA_WIDTH'(cfg_taps[32*k +: 32]);
        end
        tap_k    <= '0;
        poll_cnt <= '0;
        gap_cnt  <= '0;
        error    <= 1'b0;
        err_q    <= ERR_NONE;
        err_idx  <= '0;
      end
      case (state)
        S_WR_TAP: begin
          if (ack) tap_k <= last_tap ? 4'd0 : tap_k + 4'd1;
        end
        S_RD_TAP: begin
          if (ack) begin
            if (tap_mismatch) begin
              error   <= 1'b1;
              err_q   <= ERR_TAP;
              err_idx <= tap_k;
            end else if (!last_tap) begin
              tap_k <= tap_k + 4'd1;
            end
          end
        end
        S_POLL_RD: begin
          if (ack) begin
            status   <= 32'(rsp_data);
            poll_cnt <= poll_cnt + 32'd1;
            gap_cnt  <= '0;
            if (!fir_done && poll_last) begin
              error <= 1'b1;
              err_q <= ERR_TIMEOUT;
            end
          end
        end
        S_POLL_WAIT: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// tb/tb_fir_cfg_sequencer.sv - directed bench for fir_cfg_sequencer with a behavioural FIR AXI-Lite slave
module tb_fir_cfg_sequencer;

  localparam int TAPS = 11;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int GAP  = 8;
  localparam int PMAX = 4;
  localparam int LEN  = 600;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                go = 1'b0;
  logic [31:0]         cfg_len = '0;
  logic [TAPS*32-1:0]  cfg_taps = '0;
  logic                busy, done, error;
  logic [1:0]          err_code;
  logic [3:0]          err_idx;
  logic [31:0]         status;
  logic                awvalid, wvalid, arvalid, rready;
  logic                awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [AW-1:0]       awaddr, araddr;
  logic [DW-1:0]       wdata;
  logic [DW-1:0]       rdata = '0;

  int taps_ref [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  int n_cmp = 0;
  int n_bad = 0;

  // slave model state
  int          aw_delay = 0, w_delay = 0, corrupt_idx = -1;
  bit          never_done = 1'b0;
  logic [31:0] len_reg = '0;
  logic [31:0] tap_reg [TAPS];
  bit          ctrl_done = 1'b0;
  int          done_timer = 0;
  bit          aw_got = 1'b0, w_got = 1'b0;
  int          aw_cnt = 0, w_cnt = 0;
  logic [31:0] aw_addr_l, w_data_l;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] rd_addr [$];
  int          rd_cyc  [$];
  int          aw_hs_cnt = 0, w_hs_cnt = 0, cyc = 0;

  fir_cfg_sequencer #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .Tape_Num    (TAPS),
    .POLL_GAP    (GAP),
    .POLL_MAX    (PMAX)
  ) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .go         (go),
    .cfg_len    (cfg_len),
    .cfg_taps   (cfg_taps),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .err_idx    (err_idx),
    .status     (status),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    int idx;
    if (a == 32'h0) return {29'd0, ctrl_done, ctrl_done, 1'b0};
    if (a == 32'h10) return len_reg;
    idx = (int'(a) - 32'h20) / 4;
    if (a >= 32'h20 && idx < TAPS) return tap_reg[idx] + ((idx == corrupt_idx) ? 32'd1 : 32'd0);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic slave_write(input logic [31:0] a, input logic [31:0] d);
    int idx;
    wr_addr.push_back(a);
    wr_data.push_back(d);
    idx = (int'(a) - 32'h20) / 4;
    if (a == 32'h10) len_reg = d;
    else if (a == 32'h0 && d[0]) begin
      ctrl_done  = 1'b0;
      done_timer = never_done ? 0 : int'(len_reg) / 40;
    end else if (a >= 32'h20 && idx < TAPS) tap_reg[idx] = d;
  endtask

  // FIR slave: decides ready/valid at the falling edge for the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      awready = 1'b0;
      wready  = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      if (!rst_n) begin
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (done_timer > 0) begin
          done_timer--;
          if (done_timer == 0) ctrl_done = 1'b1;
        end
        if (awvalid && !aw_got) begin
          if (aw_cnt >= aw_delay) begin
            awready = 1'b1; aw_got = 1'b1; aw_addr_l = 32'(awaddr); aw_hs_cnt++;
          end else aw_cnt++;
        end
        if (wvalid && !w_got) begin
          if (w_cnt >= w_delay) begin
            wready = 1'b1; w_got = 1'b1; w_data_l = wdata; w_hs_cnt++;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin
          slave_write(aw_addr_l, w_data_l);
          aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
        end
        if (arvalid) begin
          arready = 1'b1;
          rvalid  = 1'b1;
          rdata   = slave_read(32'(araddr));
          rd_addr.push_back(32'(araddr));
          rd_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete(); rd_cyc.delete();
    aw_hs_cnt = 0; w_hs_cnt = 0;
  endtask

  task automatic start_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int ndone);
    int n = 0;
    ndone = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done) ndone++;
      if (!busy) break;
    end
    check({tag, "_idle_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int nd);
    check({tag, "_nwr"}, wr_addr.size(), 13);
    if (wr_addr.size() == 13) begin
      check({tag, "_len_addr"}, wr_addr[0], 32'h10);
      check({tag, "_len_data"}, wr_data[0], LEN);
      for (int k = 0; k < TAPS; k++) begin
        check({tag, "_tap_addr"}, wr_addr[1+k], 32'h20 + 32'(4*k));
        check({tag, "_tap_data"}, wr_data[1+k], 32'(taps_ref[k]));
      end
      check({tag, "_start_addr"}, wr_addr[12], 32'h0);
      check({tag, "_start_data"}, wr_data[12], 32'h1);
    end
    check({tag, "_nrd_ge12"}, 32'(rd_addr.size() >= 12), 32'd1);
    if (rd_addr.size() >= 12) begin
      for (int k = 0; k < TAPS; k++) check({tag, "_rd_addr"}, rd_addr[k], 32'h20 + 32'(4*k));
      check({tag, "_poll_addr"}, rd_addr[11], 32'h0);
    end
    check({tag, "_done_pulses"}, nd, 1);
    check({tag, "_status_done"}, 32'(status[1]), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    int nd;
    int n;
    int npoll;
    bit any_valid;
    bit gap_ok;
    int last_poll;

    cfg_len = LEN;
    for (int k = 0; k < TAPS; k++) cfg_taps[32*k +: 32] = taps_ref[k];

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_err_idx", 32'(err_idx), 0);
    check("rst_status", status, 0);
    check("rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait slave, full sequence
    clear_logs();
    start_go();
    check("t1_busy_after_go", 32'(busy), 1);
    wait_idle("t1", 1000, nd);
    check_seq("t1", nd);

    // 2: awready leads wready by 3 cycles, then the reverse
    aw_delay = 0; w_delay = 3;
    clear_logs();
    start_go();
    wait_idle("t2a", 2000, nd);
    check_seq("t2a", nd);
    check("t2a_aw_hs", aw_hs_cnt, 13);
    check("t2a_w_hs", w_hs_cnt, 13);
    aw_delay = 3; w_delay = 0;
    clear_logs();
    start_go();
    wait_idle("t2b", 2000, nd);
    check_seq("t2b", nd);
    check("t2b_aw_hs", aw_hs_cnt, 13);
    check("t2b_w_hs", w_hs_cnt, 13);
    aw_delay = 0; w_delay = 0;

    // 3: tap 5 reads back 64 instead of 63
    corrupt_idx = 5;
    clear_logs();
    start_go();
    wait_idle("t3", 1000, nd);
    repeat (3) @(negedge clk);
    check("t3_err_code", 32'(err_code), 1);
    check("t3_err_idx", 32'(err_idx), 5);
    check("t3_error", 32'(error), 1);
    check("t3_done_pulses", nd, 0);
    check("t3_nwr", wr_addr.size(), 12);
    check("t3_nrd", rd_addr.size(), 6);
    n = 0;
    foreach (wr_addr[i]) if (wr_addr[i] == 32'h0) n++;
    check("t3_no_ctrl_write", n, 0);
    corrupt_idx = -1;

    // 4: FIR never finishes, POLL_MAX polls then timeout
    never_done = 1'b1;
    clear_logs();
    start_go();
    check("t4_go_clears_error", 32'(error), 0);
    check("t4_go_clears_code", 32'(err_code), 0);
    check("t4_go_clears_idx", 32'(err_idx), 0);
    wait_idle("t4", 1000, nd);
    npoll = 0;
    gap_ok = 1'b1;
    last_poll = -1000;
    foreach (rd_addr[i]) begin
      if (rd_addr[i] == 32'h0) begin
        npoll++;
        if (rd_cyc[i] - last_poll < GAP) gap_ok = 1'b0;
        last_poll = rd_cyc[i];
      end
    end
    check("t4_npoll", npoll, PMAX);
    check("t4_poll_spacing", 32'(gap_ok), 1);
    check("t4_err_code", 32'(err_code), 2);
    check("t4_error", 32'(error), 1);
    check("t4_done_pulses", nd, 0);
    never_done = 1'b0;

    // 5: reset while reading back tap 3
    clear_logs();
    start_go();
    n = 0;
    while (n < 300 && !(arvalid && araddr == 12'h02C)) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_tap3", 32'(n < 300), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_valids_drop", {28'd0, awvalid, wvalid, arvalid, rready}, 0);
    check("t5_busy_drop", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (awvalid || wvalid || arvalid || busy) any_valid = 1'b1;
    end
    check("t5_no_resume", 32'(any_valid), 0);
    check("t5_err_code_rst", 32'(err_code), 0);
    check("t5_status_rst", status, 0);
    clear_logs();
    start_go();
    wait_idle("t5", 1000, nd);
    check_seq("t5", nd);

    // 6: go while busy and go on the done cycle are both ignored
    clear_logs();
    start_go();
    repeat (10) @(negedge clk);
    go = 1'b1;
    cfg_len = 999;
    cfg_taps = '1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    nd = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (done) begin
        nd++;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        break;
      end
    end
    check("t6_done_in_budget", 32'(n < 1000), 1);
    repeat (10) @(negedge clk);
    check("t6_no_restart_busy", 32'(busy), 0);
    check("t6_nwr", wr_addr.size(), 13);
    if (wr_data.size() > 0) check("t6_len_kept", wr_data[0], LEN);
    check("t6_error", 32'(error), 0);
    check("t6_done_pulses", nd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
